host_if_arbiter: RTL and testbench

Parametrised N-channel arbiter between host-link slaves (SPI, QSPI, future links) and the single `interface_*` register/memory bus of `array_top`. It latches single-cycle access pulses from each channel, grants one access at a time (fixed or round-robin priority), and keeps at most one read outstanding. Each read response is routed only to the channel that issued it, with a timeout that returns an error. It replaces the two-source, broadcast-response muxing in the chip top level.

---
 rtl/host_if_arbiter.sv | 248 ++++++++++++++++++++++++
 tb/tb_host_if_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_if_arbiter.sv
// host_if_arbiter: N-channel arbiter in front of the single interface_* bus.
// Each channel has a one-deep pending slot; one access is granted at a time
// and at most one read is outstanding. Read responses (or timeout errors)
// are routed back only to the channel that issued the read.
module host_if_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int DW         = 16,
  parameter int AW         = 22,
  parameter int RR_EN      = 1,
  parameter int TO_W       = 8,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH*AW-1:0] ch_addr,
  input  logic [NUM_CH-1:0]    ch_wen,
  input  logic [NUM_CH*DW-1:0] ch_wdata,
  input  logic [NUM_CH-1:0]    ch_ren,
  output logic [NUM_CH*DW-1:0] ch_rdata,
  output logic [NUM_CH-1:0]    ch_rvalid,
  output logic [NUM_CH-1:0]    ch_rerr,
  output logic [NUM_CH-1:0]    ch_wdone,
  output logic [NUM_CH-1:0]    ovf_flag,
  input  logic                 ovf_clr,
  output logic [AW-1:0]        interface_addr,
  output logic                 interface_wen,
  output logic [DW-1:0]        interface_wdata,
  output logic                 interface_ren,
  input  logic [DW-1:0]        interface_rdata,
  input  logic                 interface_rvalid,
  output logic                 stray_rvalid
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  state_t              state_q, state_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]       last_grant_q;
  logic [CW-1:0]       owner_q;

  // Pending slots
  logic [NUM_CH-1:0]   slot_valid_q;
  logic [NUM_CH-1:0]   slot_wr_q;
  logic [AW-1:0]       slot_addr_q  [NUM_CH];
  logic [DW-1:0]       slot_wdata_q [NUM_CH];
  logic [NUM_CH-1:0]   ovf_q;

  // Bus-side registers
  logic [AW-1:0]       iaddr_q;
  logic [DW-1:0]       iwdata_q;
  logic                iwen_q;
  logic                iren_q;
  logic                rv_in_q;
  logic [DW-1:0]       rd_in_q;
  logic                stray_q;

  // Channel-side response registers
  logic [NUM_CH*DW-1:0] rdata_q;
  logic [NUM_CH-1:0]    rvalid_q;
  logic [NUM_CH-1:0]    rerr_q;
  logic [NUM_CH-1:0]    wdone_q;

  // Arbitration helpers
  logic [NUM_CH-1:0]   pulse;
  logic [NUM_CH-1:0]   above_mask;
  logic [NUM_CH-1:0]   grant_vec;
  logic [NUM_CH-1:0]   req_sel;
  logic [CW-1:0]       win_idx;
  logic                win_found;
  logic                grant_en;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign pulse[gi]      = ch_wen[gi] | ch_ren[gi];
    // Channels after the last grant are searched first in round-robin mode.
    assign above_mask[gi] = (last_grant_q < CW'(gi));
    assign grant_vec[gi]  = grant_en && (win_idx == CW'(gi));
  end

  assign win_found = |slot_valid_q;

  // Winner selection: lowest index among the preferred request set
  always_comb begin
    req_sel = slot_valid_q;
    if ((RR_EN != 0) && ((slot_valid_q & above_mask) != '0)) begin
      req_sel = slot_valid_q & above_mask;
    end
    win_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_sel[k]) begin
        win_idx = CW'(k);
      end
    end
  end

  // Next-state logic for the access sequencer
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_en = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (iren_q) begin
          state_d = WAIT_RD;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_RD: begin
        if (rv_in_q) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
          if (cnt_d == TO_W'(RD_TIMEOUT)) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and timeout counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Slot occupancy and sticky overflow flags; a pulse on a granted slot refills it
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_q <= '0;
      slot_wr_q    <= '0;
      ovf_q        <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (pulse[i] && (!slot_valid_q[i] || grant_vec[i])) begin
          slot_valid_q[i] <= 1'b1;
          slot_wr_q[i]    <= ch_wen[i];
        end else if (grant_vec[i]) begin
          slot_valid_q[i] <= 1'b0;
        end
        if (ovf_clr) begin
          ovf_q[i] <= 1'b0;
        end else if (pulse[i] && slot_valid_q[i] && !grant_vec[i]) begin
          ovf_q[i] <= 1'b1;
        end
      end
    end
  end

  // Slot payload storage; only meaningful while the slot is valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (pulse[i] && (!slot_valid_q[i] || grant_vec[i])) begin
        slot_addr_q[i] <= ch_addr[i*AW +: AW];
        if (ch_wen[i]) begin
          slot_wdata_q[i] <= ch_wdata[i*DW +: DW];
        end
      end
    end
  end

  // Bus strobes, write completion and routed read responses
  always_ff @(posedge clk) begin
    if (rst) begin
      iaddr_q      <= '0;
      iwdata_q     <= '0;
      iwen_q       <= 1'b0;
      iren_q       <= 1'b0;
      wdone_q      <= '0;
      rvalid_q     <= '0;
      rerr_q       <= '0;
      rdata_q      <= '0;
      owner_q      <= '0;
      last_grant_q <= CW'(NUM_CH - 1);
    end else begin
      iwen_q   <= 1'b0;
      iren_q   <= 1'b0;
      wdone_q  <= '0;
      rvalid_q <= '0;
      rerr_q   <= '0;
      if (grant_en) begin
        iaddr_q          <= slot_addr_q[win_idx];
        iwen_q           <= slot_wr_q[win_idx];
        iren_q           <= !slot_wr_q[win_idx];
        wdone_q[win_idx] <= slot_wr_q[win_idx];
        owner_q          <= win_idx;
        last_grant_q     <= win_idx;
        if (slot_wr_q[win_idx]) begin
          iwdata_q <= slot_wdata_q[win_idx];
        end
      end
      if ((state_q == WAIT_RD) && (state_d == RESP)) begin
        rvalid_q[owner_q]                 <= 1'b1;
        rerr_q[owner_q]                   <= !rv_in_q;
        rdata_q[int'(owner_q)*DW +: DW]   <= rv_in_q ? rd_in_q : '0;
      end
    end
  end

  // Bus read return is registered first; returns outside WAIT_RD are flagged
  always_ff @(posedge clk) begin
    if (rst) begin
      rv_in_q <= 1'b0;
      rd_in_q <= '0;
      stray_q <= 1'b0;
    end else begin
      rv_in_q <= interface_rvalid && (state_q == WAIT_RD);
      rd_in_q <= interface_rdata;
      if (ovf_clr) begin
        stray_q <= 1'b0;
      end else if (interface_rvalid && (state_q != WAIT_RD)) begin
        stray_q <= 1'b1;
      end
    end
  end

  assign interface_addr  = iaddr_q;
  assign interface_wdata = iwdata_q;
  assign interface_wen   = iwen_q;
  assign interface_ren   = iren_q;
  assign ch_rdata        = rdata_q;
  assign ch_rvalid       = rvalid_q;
  assign ch_rerr         = rerr_q;
  assign ch_wdone        = wdone_q;
  assign ovf_flag        = ovf_q;
  assign stray_rvalid    = stray_q;

endmodule

// File: tb/tb_host_if_arbiter.sv
// Testbench for host_if_arbiter: random channel traffic, a responding bus
// model and a scoreboard of expected bus strobes and channel responses.
`timescale 1ns/1ps
module tb_host_if_arbiter;
  localparam int NUM_CH     = 3;
  localparam int DW         = 16;
  localparam int AW         = 22;
  localparam int TO_W       = 4;
  localparam int RD_TIMEOUT = 6;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_CH*AW-1:0] ch_addr;
  logic [NUM_CH-1:0]    ch_wen;
  logic [NUM_CH*DW-1:0] ch_wdata;
  logic [NUM_CH-1:0]    ch_ren;
  logic [NUM_CH*DW-1:0] ch_rdata;
  logic [NUM_CH-1:0]    ch_rvalid;
  logic [NUM_CH-1:0]    ch_rerr;
  logic [NUM_CH-1:0]    ch_wdone;
  logic [NUM_CH-1:0]    ovf_flag;
  logic                 ovf_clr;
  logic [AW-1:0]        interface_addr;
  logic                 interface_wen;
  logic [DW-1:0]        interface_wdata;
  logic                 interface_ren;
  logic [DW-1:0]        interface_rdata;
  logic                 interface_rvalid;
  logic                 stray_rvalid;

  always #5 clk = ~clk;

  host_if_arbiter #(
    .NUM_CH(NUM_CH), .DW(DW), .AW(AW), .RR_EN(1), .TO_W(TO_W), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_addr(ch_addr), .ch_wen(ch_wen), .ch_wdata(ch_wdata), .ch_ren(ch_ren),
    .ch_rdata(ch_rdata), .ch_rvalid(ch_rvalid), .ch_rerr(ch_rerr), .ch_wdone(ch_wdone),
    .ovf_flag(ovf_flag), .ovf_clr(ovf_clr),
    .interface_addr(interface_addr), .interface_wen(interface_wen),
    .interface_wdata(interface_wdata), .interface_ren(interface_ren),
    .interface_rdata(interface_rdata), .interface_rvalid(interface_rvalid),
    .stray_rvalid(stray_rvalid)
  );

  typedef struct {
    int          cyc;
    int          ch;
    bit          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } bus_t;

  typedef struct {
    int          cyc;
    int          ch;
    bit          err;
    logic [DW-1:0] data;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  bit [NUM_CH-1:0] m_valid;
  bit [NUM_CH-1:0] m_wr;
  logic [AW-1:0]   m_addr [NUM_CH];
  logic [DW-1:0]   m_data [NUM_CH];
  int              m_last;
  int              free_cyc;
  int              wait_lo, wait_hi;
  int              rsp_cyc;
  logic [DW-1:0]   rsp_dat;
  bit [NUM_CH-1:0] exp_ovf;
  bit              exp_stray;

  // Stimulus controls
  bit              rand_en, force_never, rst_now, post_rst_chk;
  bit [NUM_CH-1:0] dir_wen, dir_ren;
  logic [AW-1:0]   dir_addr;
  logic [DW-1:0]   dir_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop the scoreboard whenever the DUT presents a strobe or response
  always @(negedge clk) begin : monitor
    bus_t e;
    rsp_t r;
    logic [NUM_CH-1:0] exp_wd;
    logic [NUM_CH-1:0] exp_rv;
    logic [NUM_CH-1:0] exp_re;
    if (interface_wen || interface_ren) begin
      if (bus_q.size() == 0) begin
        check("bus_unexpected", {interface_wen, interface_ren}, 0);
      end else begin
        e = bus_q.pop_front();
        exp_wd = '0;
        if (e.wr) exp_wd[e.ch] = 1'b1;
        $display("bus %s ch%0d addr=%h data=%h cycle %0d", e.wr ? "WR" : "RD", e.ch,
                 interface_addr, interface_wdata, cyc);
        check("bus_cycle", cyc, e.cyc);
        check("bus_kind", {interface_wen, interface_ren}, e.wr ? 2'b10 : 2'b01);
        check("bus_addr", interface_addr, e.addr);
        if (e.wr) check("bus_wdata", interface_wdata, e.data);
        check("wdone", ch_wdone, exp_wd);
      end
    end else begin
      check("wdone_idle", ch_wdone, 0);
    end
    if (ch_rvalid != '0) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", ch_rvalid, 0);
      end else begin
        r = rsp_q.pop_front();
        exp_rv = '0;
        exp_re = '0;
        exp_rv[r.ch] = 1'b1;
        exp_re[r.ch] = r.err;
        $display("rsp ch%0d data=%h err=%0d cycle %0d", r.ch, ch_rdata[r.ch*DW +: DW], r.err, cyc);
        check("rsp_cycle", cyc, r.cyc);
        check("rsp_rvalid", ch_rvalid, exp_rv);
        check("rsp_rerr", ch_rerr, exp_re);
        check("rsp_rdata", ch_rdata[r.ch*DW +: DW], r.data);
      end
    end else begin
      check("rerr_idle", ch_rerr, 0);
    end
  end

  // One clock cycle: check sticky flags, drive stimulus, advance the model
  task automatic cycle_step();
    int c, w, s, lat, rr;
    bit [NUM_CH-1:0] wen, ren, drop;
    logic [AW-1:0] a [NUM_CH];
    logic [DW-1:0] d [NUM_CH];
    bit rv, clr, stray_ev;
    @(posedge clk);
    #1;
    c = cyc;
    check("ovf_flag", ovf_flag, exp_ovf);
    check("stray_rvalid", stray_rvalid, exp_stray);
    if (post_rst_chk) begin
      post_rst_chk = 1'b0;
      check("rst_bus", {interface_wen, interface_ren, interface_addr, interface_wdata}, 0);
      check("rst_ch", {ch_rvalid, ch_rerr, ch_wdone, ch_rdata}, 0);
    end

    wen = '0;
    ren = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      a[i] = AW'($urandom);
      d[i] = DW'($urandom);
      if (rand_en) begin
        rr = $urandom_range(0, 99);
        if (rr < 9) wen[i] = 1'b1;
        else if (rr < 18) ren[i] = 1'b1;
        else if (rr < 20) begin wen[i] = 1'b1; ren[i] = 1'b1; end
      end
    end
    if (!rand_en) begin
      wen = dir_wen;
      ren = dir_ren;
      dir_wen = '0;
      dir_ren = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        a[i] = dir_addr;
        d[i] = dir_data;
      end
    end
    clr = rand_en && ($urandom_range(0, 59) == 0);
    rv  = (c == rsp_cyc);
    if (!rv && rand_en && !(c >= wait_lo && c <= wait_hi) && $urandom_range(0, 39) == 0) rv = 1'b1;

    rst = rst_now;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_addr[i*AW +: AW]  = a[i];
      ch_wdata[i*DW +: DW] = d[i];
    end
    ch_wen           = rst_now ? '0 : wen;
    ch_ren           = rst_now ? '0 : ren;
    ovf_clr          = clr;
    interface_rvalid = rst_now ? 1'b0 : rv;
    interface_rdata  = (c == rsp_cyc) ? rsp_dat : DW'($urandom);

    if (rst_now) begin
      m_valid   = '0;
      m_last    = NUM_CH - 1;
      free_cyc  = c + 1;
      exp_ovf   = '0;
      exp_stray = 1'b0;
      wait_lo   = -100;
      wait_hi   = -100;
      while (rsp_q.size() > 0 && rsp_q[rsp_q.size()-1].cyc > c) void'(rsp_q.pop_back());
      while (bus_q.size() > 0 && bus_q[bus_q.size()-1].cyc > c) void'(bus_q.pop_back());
      rsp_cyc   = c + 2;
      rsp_dat   = DW'($urandom);
      post_rst_chk = 1'b1;
      return;
    end

    // Grant: round-robin search starting after the last granted channel
    w = -1;
    if (c >= free_cyc) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        int cand;
        cand = (m_last + k) % NUM_CH;
        if (w < 0 && m_valid[cand]) w = cand;
      end
    end
    if (w >= 0) begin
      m_last = w;
      bus_q.push_back('{cyc: c + 1, ch: w, wr: m_wr[w], addr: m_addr[w], data: m_data[w]});
      if (m_wr[w]) begin
        free_cyc = c + 2;
      end else begin
        s = c + 1;
        if (force_never || $urandom_range(0, 3) == 0) begin
          rsp_q.push_back('{cyc: s + RD_TIMEOUT + 1, ch: w, err: 1'b1, data: '0});
          free_cyc = s + RD_TIMEOUT + 2;
          wait_lo  = s + 1;
          wait_hi  = s + RD_TIMEOUT;
          rsp_cyc  = (!force_never && $urandom_range(0, 1) == 1) ? s + RD_TIMEOUT + 1 : -100;
          rsp_dat  = DW'($urandom);
        end else begin
          lat      = $urandom_range(1, RD_TIMEOUT - 1);
          rsp_dat  = DW'($urandom);
          rsp_cyc  = s + lat;
          rsp_q.push_back('{cyc: s + lat + 2, ch: w, err: 1'b0, data: rsp_dat});
          free_cyc = s + lat + 3;
          wait_lo  = s + 1;
          wait_hi  = s + lat + 1;
        end
      end
    end

    // Slot loading: busy slot that is not being granted drops the pulse
    drop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wen[i] || ren[i]) begin
        if (m_valid[i] && w != i) begin
          drop[i] = 1'b1;
        end else begin
          m_valid[i] = 1'b1;
          m_wr[i]    = wen[i];
          m_addr[i]  = a[i];
          if (wen[i]) m_data[i] = d[i];
        end
      end else if (w == i) begin
        m_valid[i] = 1'b0;
      end
    end
    stray_ev  = rv && !(c >= wait_lo && c <= wait_hi);
    exp_ovf   = clr ? '0 : (exp_ovf | drop);
    exp_stray = clr ? 1'b0 : (exp_stray | stray_ev);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      if (m_valid == '0 && cyc + 1 >= free_cyc && bus_q.size() == 0 && rsp_q.size() == 0) break;
      cycle_step();
    end
  endtask

  initial begin
    rst = 1'b1;
    ch_addr = '0; ch_wdata = '0; ch_wen = '0; ch_ren = '0;
    ovf_clr = 1'b0; interface_rdata = '0; interface_rvalid = 1'b0;
    m_valid = '0; m_wr = '0; m_last = NUM_CH - 1; free_cyc = 0;
    wait_lo = -100; wait_hi = -100; rsp_cyc = -100; rsp_dat = '0;
    exp_ovf = '0; exp_stray = 1'b0;
    rand_en = 1'b0; force_never = 1'b0; post_rst_chk = 1'b0;
    dir_wen = '0; dir_ren = '0; dir_addr = '0; dir_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_addr[i] = '0;
      m_data[i] = '0;
    end

    rst_now = 1'b1;
    cycle_step();
    cycle_step();
    rst_now = 1'b0;
    cycle_step();

    // Single write on channel 0
    dir_wen = 3'b001; dir_addr = 22'h12345; dir_data = 16'hBEEF;
    cycle_step();
    wait_idle();

    // Read on channel 1
    dir_ren = 3'b010; dir_addr = 22'h00010;
    cycle_step();
    wait_idle();

    // Simultaneous writes, twice
    dir_wen = 3'b011; dir_addr = 22'h00ABC; dir_data = 16'h1234;
    cycle_step();
    wait_idle();
    dir_wen = 3'b011; dir_addr = 22'h00DEF; dir_data = 16'h5678;
    cycle_step();
    wait_idle();

    // Random traffic
    rand_en = 1'b1;
    repeat (3000) cycle_step();
    rand_en = 1'b0;
    wait_idle();

    // Reset while a read is outstanding
    force_never = 1'b1;
    dir_ren = 3'b010; dir_addr = 22'h00777;
    cycle_step();
    repeat (3) cycle_step();
    rst_now = 1'b1;
    cycle_step();
    rst_now = 1'b0;
    force_never = 1'b0;
    dir_wen = 3'b100; dir_addr = 22'h3FFFF; dir_data = 16'hC0DE;
    cycle_step();
    wait_idle();

    rand_en = 1'b1;
    repeat (300) cycle_step();
    rand_en = 1'b0;
    wait_idle();
    cycle_step();

    check("bus_q_empty", bus_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
